// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// display_pkg : shared types and helpers for the display scan controller
// Revision    : 1.0
// ============================================================================
package display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2
  } state_t;

  localparam int SEG_W = 7;

  function automatic int slot_len(input int blank_cycles, input int br_w);
    return blank_cycles + (1 << br_w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/display_scan_ctrl_timer.sv
`default_nettype none
// ============================================================================
// scan_slot_timer : BLANK/ON slot sequencer with latched PWM brightness
// Revision        : 1.0
// ============================================================================
module scan_slot_timer
  import display_pkg::*;
#(
  parameter int BLANK_CYCLES = 4,
  parameter int BR_W         = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic [BR_W-1:0] brightness,
  output logic            slot_end,
  output logic            lit,
  output logic            in_blank,
  output logic            idle
);

  // One counter serves both phases, so size it for the whole slot.
  localparam int CNT_W = $clog2(slot_len(BLANK_CYCLES, BR_W));
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'((1 << BR_W) - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BR_W-1:0]   br_q, br_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      br_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    br_d     = br_q;
    slot_end = 1'b0;
    lit      = 1'b0;
    in_blank = 1'b0;
    idle     = 1'b0;
    case (state_q)
      IDLE: begin
        idle  = 1'b1;
        cnt_d = '0;
        if (enable) begin
          state_d = BLANK;
          br_d    = brightness;
        end
      end
      BLANK: begin
        in_blank = 1'b1;
        if (cnt_q == BLANK_LAST) begin
          state_d = ON;
          cnt_d   = '0;
        end
      end
      ON: begin
        lit = (cnt_q < CNT_W'(br_q));
        if (cnt_q == ON_LAST) begin
          slot_end = 1'b1;
          state_d  = BLANK;
          cnt_d    = '0;
          br_d     = brightness;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// display_scan_ctrl : multiplexed 7-seg scanner with double-buffered patterns
// Revision          : 1.0
// ============================================================================
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 2,
  parameter int BLANK_CYCLES = 4,
  parameter int BR_W         = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [BR_W-1:0]             brightness,
  input  logic                        upd_valid,
  input  logic [SEG_W*NUM_DIGITS-1:0] upd_data,
  output logic                        upd_ready,
  output logic [SEG_W-1:0]            seg,
  output logic [NUM_DIGITS-1:0]       anode,
  output logic                        frame_tick
);

  localparam int DIG_W = $clog2(NUM_DIGITS);
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(NUM_DIGITS - 1);

  logic                        slot_end, lit, in_blank, idle;
  logic [DIG_W-1:0]            digit;
  logic [SEG_W*NUM_DIGITS-1:0] active, shadow;
  logic                        pending;
  logic                        boundary, show;

  scan_slot_timer #(
    .BLANK_CYCLES (BLANK_CYCLES),
    .BR_W         (BR_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .brightness (brightness),
    .slot_end   (slot_end),
    .lit        (lit),
    .in_blank   (in_blank),
    .idle       (idle)
  );

  assign boundary  = slot_end && (digit == DIG_LAST);
  assign show      = lit && !in_blank;
  assign upd_ready = !pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit <= '0;
    end else if (idle || !enable) begin
      digit <= '0;
    end else if (slot_end) begin
      digit <= boundary ? '0 : digit + 1'b1;
    end
  end

  // Capture needs an empty shadow, so a capture and an apply never coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active  <= '0;
      shadow  <= '0;
      pending <= 1'b0;
    end else if (upd_valid && !pending) begin
      shadow  <= upd_data;
      pending <= 1'b1;
    end else if (pending && (boundary || idle)) begin
      active  <= shadow;
      pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg        <= '0;
      anode      <= '0;
      frame_tick <= 1'b0;
    end else begin
      seg        <= show ? active[int'(digit)*SEG_W +: SEG_W] : '0;
      anode      <= show ? (NUM_DIGITS'(1) << digit) : '0;
      frame_tick <= boundary;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// tb_display_scan_ctrl : directed self-checking bench (2 digits, slot 10)
// Revision             : 1.0
// ============================================================================
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [2:0]  brightness;
  logic        upd_valid;
  logic [13:0] upd_data;
  logic        upd_ready;
  logic [6:0]  seg;
  logic [1:0]  anode;
  logic        frame_tick;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected-state model: active/shadow patterns, pending flag, latched brightness.
  logic [13:0] act_m = '0;
  logic [13:0] shd_m = '0;
  logic        pend_m = 1'b0;
  int          br_m = 0;

  display_scan_ctrl #(
    .NUM_DIGITS   (2),
    .BLANK_CYCLES (2),
    .BR_W         (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .brightness (brightness),
    .upd_valid  (upd_valid),
    .upd_data   (upd_data),
    .upd_ready  (upd_ready),
    .seg        (seg),
    .anode      (anode),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Walks output cycles 1..stop_at of one frame, with optional update offer and
  // brightness change driven right after sampling the given cycle.
  task automatic check_frame(input int stop_at, input int upd_from, input int upd_to,
                             input logic [13:0] d_first, input logic [13:0] d_rest,
                             input int br_at, input logic [2:0] br_new);
    for (int k = 1; k <= stop_at; k++) begin
      int   slot, pos;
      logic lit, pend_old;
      @(posedge clk); #1;
      slot = (k - 1) / 10;
      pos  = (k - 1) % 10;
      lit  = (pos >= 2) && ((pos - 2) < br_m);
      check_eq("anode", 32'(anode), lit ? 32'(1 << slot) : 32'd0);
      check_eq("seg", 32'(seg), lit ? 32'(act_m[slot*7 +: 7]) : 32'd0);
      check_eq("frame_tick", 32'(frame_tick), 32'(k == 20));
      pend_old = pend_m;
      if (k == 20 && pend_old) begin
        act_m  = shd_m;
        pend_m = 1'b0;
      end
      if (upd_valid && !pend_old) begin
        shd_m  = upd_data;
        pend_m = 1'b1;
      end
      if (k == 10 || k == 20) br_m = int'(brightness);
      check_eq("upd_ready", 32'(upd_ready), 32'(!pend_m));
      if (k >= upd_from && k <= upd_to) begin
        upd_valid = 1'b1;
        upd_data  = (k == upd_from) ? d_first : d_rest;
      end else begin
        upd_valid = 1'b0;
      end
      if (k == br_at) brightness = br_new;
    end
  endtask

  task automatic enable_on();
    enable = 1'b1;
    br_m   = int'(brightness);
    @(posedge clk); #1;
    check_eq("idle_anode", 32'(anode), 32'd0);
    if (pend_m) begin
      act_m  = shd_m;
      pend_m = 1'b0;
    end
  endtask

  task automatic idle_update(input logic [13:0] d);
    upd_valid = 1'b1;
    upd_data  = d;
    @(posedge clk); #1;
    check_eq("idle_ready_lo", 32'(upd_ready), 32'd0);
    check_eq("idle_anode", 32'(anode), 32'd0);
    upd_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("idle_ready_hi", 32'(upd_ready), 32'd1);
    act_m  = d;
    shd_m  = d;
    pend_m = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; brightness = 3'd0; upd_valid = 1'b0; upd_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_seg", 32'(seg), 32'd0);
    check_eq("rst_anode", 32'(anode), 32'd0);
    check_eq("rst_tick", 32'(frame_tick), 32'd0);
    check_eq("rst_ready", 32'(upd_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic scan at full brightness.
    brightness = 3'd7;
    idle_update({7'h30, 7'h7E});
    enable_on();
    check_frame(20, 0, 0, '0, '0, 0, 3'd0);
    check_frame(20, 0, 0, '0, '0, 0, 3'd0);

    // Brightness 0: dark, tick continues.
    check_frame(20, 0, 0, '0, '0, 15, 3'd0);
    check_frame(20, 0, 0, '0, '0, 0, 3'd0);
    check_frame(20, 0, 0, '0, '0, 0, 3'd0);

    // Back to 7 (takes effect from digit 1), then a mid-frame update plus stalled offers.
    check_frame(20, 0, 0, '0, '0, 3, 3'd7);
    check_frame(20, 5, 12, {7'h6D, 7'h79}, 14'h3FFF, 0, 3'd0);
    check_frame(20, 0, 0, '0, '0, 0, 3'd0);

    // Update captured on the boundary cycle waits one more frame.
    check_frame(20, 19, 19, {7'h06, 7'h5B}, '0, 0, 3'd0);
    check_frame(20, 0, 0, '0, '0, 0, 3'd0);
    check_frame(20, 0, 0, '0, '0, 0, 3'd0);

    // Brightness 7->3 during digit 0 ON.
    check_frame(20, 0, 0, '0, '0, 5, 3'd3);

    // Asynchronous reset mid-ON with an update pending.
    check_frame(4, 1, 1, {7'h3F, 7'h66}, '0, 0, 3'd0);
    #2 rst = 1'b1;
    #1;
    check_eq("async_seg", 32'(seg), 32'd0);
    check_eq("async_anode", 32'(anode), 32'd0);
    check_eq("async_ready", 32'(upd_ready), 32'd1);
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    act_m = '0; shd_m = '0; pend_m = 1'b0;
    check_eq("post_rst_ready", 32'(upd_ready), 32'd1);
    brightness = 3'd7;
    enable_on();
    check_frame(20, 0, 0, '0, '0, 0, 3'd0);

    // Enable dropped mid-slot, then restart at digit 0.
    enable = 1'b0;
    idle_update({7'h5B, 7'h4F});
    enable_on();
    check_frame(6, 0, 0, '0, '0, 0, 3'd0);
    enable = 1'b0;
    @(posedge clk); #1;
    check_eq("drop_anode1", 32'(anode), 32'd1);
    check_eq("drop_seg1", 32'(seg), 32'h4F);
    @(posedge clk); #1;
    check_eq("drop_anode2", 32'(anode), 32'd0);
    check_eq("drop_seg2", 32'(seg), 32'd0);
    check_eq("drop_tick", 32'(frame_tick), 32'd0);
    enable_on();
    check_frame(20, 0, 0, '0, '0, 0, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Scan scheduler for the multiplexed seven-segment display on the lab board. Time-slices NUM_DIGITS digits onto one shared seg bus with per-digit anode enables, a blanking dead-time between digits against ghosting, and PWM brightness control. Digit patterns arrive through a valid/ready update port and are double-buffered: they are applied only at frame boundaries, so the display never shows a half-updated frame.

Parameters:
NUM_DIGITS, 2, number of multiplexed digits (>=2)
BLANK_CYCLES, 4, dead-time cycles at start of each digit slot (>=1)
BR_W, 8, brightness width; ON phase lasts 2**BR_W cycles

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
enable  in  1  scanning enabled; 0 blanks display and holds scan at start
brightness  in  BR_W  lit cycles per ON phase (0 = dark, 2**BR_W-1 = max)
upd_valid  in  1  new frame data offered
upd_data  in  7*NUM_DIGITS  digit i pattern at bits [7i+6:7i]
upd_ready  out  1  shadow buffer free; equals !pending
seg  out  7  segment pattern of the lit digit, 0 when no digit lit
anode  out  NUM_DIGITS  one-hot active-high digit enable, all 0 when blank
frame_tick  out  1  one-cycle pulse on the last cycle of each frame

Behaviour:
- Clock is clk. Reset is rst: asynchronous, active-high. While rst=1: seg=0, anode=0, frame_tick=0, active buffer=0, shadow=0, pending=0 (upd_ready=1), state=IDLE, digit=0, counters=0.
- Slot = BLANK_CYCLES + 2**BR_W cycles. Frame = NUM_DIGITS slots.
- States: IDLE, BLANK, ON.
  - IDLE: entered on reset or enable=0. Outputs 0. Goes to BLANK of digit 0 on the first cycle enable=1.
  - BLANK: cnt 0..BLANK_CYCLES-1. anode=0, seg=0. brightness is latched into br_q on slot entry. Goes to ON after BLANK_CYCLES cycles.
  - ON: cnt 0..2**BR_W-1. anode[digit]=1 and seg=active[digit] while cnt<br_q, else both 0. At the end of ON, go to BLANK with digit+1; digit wraps from NUM_DIGITS-1 to 0.
- seg, anode and frame_tick are registered. They reflect the state/counter of the previous cycle (1-cycle latency). The first BLANK cycle after enable rises appears on the outputs one cycle later.
- frame_tick: asserted on the output cycle that corresponds to the last ON cycle of digit NUM_DIGITS-1. Never asserted in IDLE.
- Frame boundary is that same last cycle.
- Update handshake:
  - A capture occurs when upd_valid & upd_ready: shadow<=upd_data, pending<=1.
  - At a frame boundary with pending=1: active<=shadow, pending<=0.
  - Capture on the boundary cycle: only possible if pending was 0. The new data waits for the next boundary (no same-cycle bypass).
  - In IDLE, any pending shadow is applied on the next cycle.
  - Data is never overwritten: upd_ready=0 while pending.
- Brightness change mid-slot takes effect only at the next slot.
- enable falling mid-slot: next cycle the state is IDLE and the outputs blank on the following output cycle. The scan restarts at digit 0.
- Reset asserted mid-operation clears all outputs asynchronously, without waiting for a clock edge.

Decomposition:
- Shared package display_pkg:
  - state enum {IDLE, BLANK, ON}
  - SEG_W=7 constant
  - function slot_len(BLANK_CYCLES, BR_W)
- One sub-module, scan_slot_timer:
  - owns the BLANK/ON counter and br_q compare
  - emits slot_end, lit and in_blank
- The top module owns the digit index, double buffer, handshake and output registers.

Test Plan:
All scenarios use NUM_DIGITS=2, BLANK_CYCLES=2, BR_W=3 (slot 10, frame 20).
1. enable=0; send upd_data={0x30,0x7E}, brightness=7; raise enable -> after 1-cycle latency: anode=00 for 2 cycles, anode=01/seg=0x7E for 7, 00 for 1, 00 for 2, anode=10/seg=0x30 for 7, 00 for 1; frame_tick on cycle 20, repeating every 20.
2. brightness=0 -> anode and seg stay 0 forever; frame_tick still pulses every 20 cycles.
3. Mid-frame update to {0x6D,0x79} -> upd_ready=0 from the next cycle; a second upd_valid is stalled; the display keeps the old patterns until frame_tick; the new patterns appear in the next frame; upd_ready returns to 1 after the boundary.
4. Update captured exactly on the frame-boundary cycle -> old patterns shown for one more full frame; new patterns applied at the following boundary.
5. brightness changed 7->3 during digit 0 ON -> digit 0 stays lit 7 cycles; digit 1 is lit 3 cycles.
6. rst pulse mid-ON with pending=1 -> seg/anode go 0 asynchronously; after release upd_ready=1 and active=0; enable=1 restarts at digit 0 BLANK. Also: enable dropped mid-slot -> blank within 2 cycles and restart at digit 0.
